ifetch_queue: RTL and testbench

Instruction fetch front end for the five-stage core. Generates the sequential PC, issues word reads to instruction memory over a valid/ready request channel, and collects in-order responses into a DEPTH-entry prefetch queue. Presents the queue head to the fetch/decode pipeline register. Honours hazard-unit stalls through a ready signal, and flushes on control-flow redirects, including responses still in flight.

---
 rtl/ifetch_queue.sv | 130 +++++++++++++
 tb/tb_ifetch_queue.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: sequential PC, credit-limited IMEM requests, in-order prefetch queue.
// Optional same-cycle response bypass when the queue is empty: define IFETCH_BYPASS_EN.
module ifetch_queue #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          DEPTH     = 4,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        CLK,
   input  logic        RST,
   output logic        IMEM_REQ_VALID,
   input  logic        IMEM_REQ_READY,
   output logic [13:0] IMEM_ADDR,
   input  logic        IMEM_RSP_VALID,
   input  logic [31:0] IMEM_RSP_DATA,
   input  logic        REDIRECT,
   input  logic [31:0] REDIRECT_PC,
   input  logic        DEC_READY,
   output logic        FD_VALID,
   output logic [31:0] FD_PC,
   output logic [31:0] FD_NEXTPC,
   output logic [31:0] FD_IR
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int SW = PW + 2;
   // Drop counter is one bit wider: repeated redirects against a slow memory can
   // leave more than DEPTH stale responses pending.
   localparam int DW = PW + 2;

   typedef logic [PW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;
   typedef logic [DW-1:0] drp_t;

   logic [31:0] pc_q;
   logic [31:0] q_pc    [DEPTH];
   logic [31:0] q_ir    [DEPTH];
   logic [31:0] tag_mem [DEPTH];
   ptr_t        rd_ptr, wr_ptr, tag_rd, tag_wr;
   cnt_t        count, outstanding;
   drp_t        drop;

   logic [31:0] reset_pc_al, redirect_pc_al;
   logic [SW-1:0] credit_sum;
   logic        q_empty, req_fire, rsp_drop, rsp_take, rsp_any;
   logic        bypass, push_q, pop_q;

   assign reset_pc_al    = RESET_PC & ~32'd3;
   assign redirect_pc_al = REDIRECT_PC & ~32'd3;

   // Request channel: a word read transfers on a cycle where IMEM_REQ_VALID and
   // IMEM_REQ_READY are both high; while VALID is high without READY, IMEM_ADDR holds.
   assign credit_sum     = SW'(count) + SW'(outstanding);
   assign IMEM_REQ_VALID = !RST && !REDIRECT && (credit_sum < SW'(DEPTH));
   assign IMEM_ADDR      = pc_q[15:2];
   assign req_fire       = IMEM_REQ_VALID && IMEM_REQ_READY;

   assign q_empty  = (count == '0);
   assign rsp_drop = IMEM_RSP_VALID && (drop != '0);
   assign rsp_take = IMEM_RSP_VALID && (drop == '0) && (outstanding != '0);
   assign rsp_any  = IMEM_RSP_VALID && ((drop != '0) || (outstanding != '0));

`ifdef IFETCH_BYPASS_EN
   assign bypass = q_empty && rsp_take && !REDIRECT;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed word taken by decode the same cycle never enters the queue.
   assign push_q = rsp_take && !(bypass && DEC_READY);
   assign pop_q  = !q_empty && DEC_READY;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pc_q        <= reset_pc_al;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         tag_rd      <= '0;
         tag_wr      <= '0;
         count       <= '0;
         outstanding <= '0;
         drop        <= '0;
      end else if (REDIRECT) begin
         pc_q        <= redirect_pc_al;
         rd_ptr      <= wr_ptr;
         tag_rd      <= tag_wr;
         count       <= '0;
         outstanding <= '0;
         drop        <= drop + DW'(outstanding) - DW'(rsp_any);
      end else begin
         if (req_fire) begin
            pc_q   <= pc_q + 32'd4;
            tag_wr <= tag_wr + ptr_t'(1);
         end
         if (rsp_take) tag_rd <= tag_rd + ptr_t'(1);
         if (push_q)   wr_ptr <= wr_ptr + ptr_t'(1);
         if (pop_q)    rd_ptr <= rd_ptr + ptr_t'(1);
         count       <= count + cnt_t'(push_q) - cnt_t'(pop_q);
         outstanding <= outstanding + cnt_t'(req_fire) - cnt_t'(rsp_take);
         drop        <= drop - DW'(rsp_drop);
      end
   end

   // Storage needs no reset: occupancy is tracked entirely by the counters above.
   always_ff @(posedge CLK) begin
      if (req_fire) tag_mem[tag_wr] <= pc_q;
      if (push_q && !REDIRECT) begin
         q_pc[wr_ptr] <= tag_mem[tag_rd];
         q_ir[wr_ptr] <= IMEM_RSP_DATA;
      end
   end

   always_comb begin
      FD_VALID = 1'b0;
      FD_PC    = 32'd0;
      FD_IR    = NOP_INSTR;
      if (!q_empty) begin
         FD_VALID = 1'b1;
         FD_PC    = q_pc[rd_ptr];
         FD_IR    = q_ir[rd_ptr];
      end else if (bypass) begin
         FD_VALID = 1'b1;
         FD_PC    = tag_mem[tag_rd];
         FD_IR    = IMEM_RSP_DATA;
      end
   end

   assign FD_NEXTPC = FD_PC + 32'd4;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: RESET_PC=0x100, DEPTH=4, variable-latency in-order memory model.
module tb_ifetch_queue;

   logic        CLK;
   logic        RST = 1'b1;
   logic        IMEM_REQ_VALID;
   logic        IMEM_REQ_READY = 1'b1;
   logic [13:0] IMEM_ADDR;
   logic        IMEM_RSP_VALID = 1'b0;
   logic [31:0] IMEM_RSP_DATA = 32'h0;
   logic        REDIRECT = 1'b0;
   logic [31:0] REDIRECT_PC = 32'h0;
   logic        DEC_READY = 1'b1;
   logic        FD_VALID;
   logic [31:0] FD_PC;
   logic [31:0] FD_NEXTPC;
   logic [31:0] FD_IR;

   int n_tests = 0;
   int n_fail  = 0;
   int mem_lat = 1;

`ifdef IFETCH_BYPASS_EN
   localparam int BYP = 1;
`else
   localparam int BYP = 0;
`endif

   ifetch_queue #(
      .RESET_PC (32'h0000_0100),
      .DEPTH    (4),
      .NOP_INSTR(32'h0000_0013)
   ) dut (
      .CLK           (CLK),
      .RST           (RST),
      .IMEM_REQ_VALID(IMEM_REQ_VALID),
      .IMEM_REQ_READY(IMEM_REQ_READY),
      .IMEM_ADDR     (IMEM_ADDR),
      .IMEM_RSP_VALID(IMEM_RSP_VALID),
      .IMEM_RSP_DATA (IMEM_RSP_DATA),
      .REDIRECT      (REDIRECT),
      .REDIRECT_PC   (REDIRECT_PC),
      .DEC_READY     (DEC_READY),
      .FD_VALID      (FD_VALID),
      .FD_PC         (FD_PC),
      .FD_NEXTPC     (FD_NEXTPC),
      .FD_IR         (FD_IR)
   );

   // clock
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic logic [31:0] mem_word(input logic [13:0] a);
      return 32'hC000_0000 | {18'h0, a};
   endfunction

   // memory: samples the handshake late in the cycle, answers mem_lat cycles after acceptance
   logic        pipe_v [8];
   logic [13:0] pipe_a [8];
   always begin : mem_model
      logic        f;
      logic [13:0] a;
      @(negedge CLK);
      #3;
      f = IMEM_REQ_VALID && IMEM_REQ_READY;
      a = IMEM_ADDR;
      @(posedge CLK);
      #1;
      if (RST) begin
         for (int i = 0; i < 8; i++) begin
            pipe_v[i] = 1'b0;
            pipe_a[i] = 14'h0;
         end
      end else begin
         for (int i = 0; i < 7; i++) begin
            pipe_v[i] = pipe_v[i+1];
            pipe_a[i] = pipe_a[i+1];
         end
         pipe_v[7] = 1'b0;
         pipe_v[mem_lat-1] = f;
         pipe_a[mem_lat-1] = a;
      end
      IMEM_RSP_VALID = pipe_v[0];
      IMEM_RSP_DATA  = pipe_v[0] ? mem_word(pipe_a[0]) : 32'hDEAD_BEEF;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // leaves RST high at a negedge; caller releases it
   task automatic do_reset(input int lat, input logic dec);
      @(negedge CLK);
      RST = 1'b1;
      mem_lat = lat;
      DEC_READY = dec;
      IMEM_REQ_READY = 1'b1;
      REDIRECT = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge CLK);
      #1;
      n_tests++; if (FD_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_fd_valid got %b exp 0", FD_VALID); end
      n_tests++; if (FD_PC !== 32'h0) begin n_fail++; $display("FAIL reset_fd_pc got %h exp 00000000", FD_PC); end
      n_tests++; if (FD_NEXTPC !== 32'h4) begin n_fail++; $display("FAIL reset_fd_nextpc got %h exp 00000004", FD_NEXTPC); end
      n_tests++; if (FD_IR !== 32'h13) begin n_fail++; $display("FAIL reset_fd_ir got %h exp 00000013", FD_IR); end
      n_tests++; if (IMEM_REQ_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid got %b exp 0", IMEM_REQ_VALID); end
   endtask

   task automatic test_fetch();
      int fv;
      fv = 2 - BYP;
      do_reset(1, 1'b1);
      RST = 1'b0;
      #1;
      n_tests++; if (IMEM_REQ_VALID !== 1'b1 || IMEM_ADDR !== 14'h40) begin n_fail++; $display("FAIL fetch_first_req got v=%b a=%h exp v=1 a=0040", IMEM_REQ_VALID, IMEM_ADDR); end
      n_tests++; if (FD_VALID !== 1'b0) begin n_fail++; $display("FAIL fetch_c0_valid got %b exp 0", FD_VALID); end
      for (int c = 1; c <= fv + 2; c++) begin
         @(negedge CLK);
         #1;
         if (c < fv) begin
            n_tests++; if (FD_VALID !== 1'b0) begin n_fail++; $display("FAIL fetch_early_valid c%0d got %b exp 0", c, FD_VALID); end
         end else begin
            n_tests++;
            if (FD_VALID !== 1'b1 || FD_PC !== 32'h100 + 32'(4 * (c - fv)) ||
                FD_NEXTPC !== 32'h104 + 32'(4 * (c - fv)) || FD_IR !== mem_word(14'h40 + 14'(c - fv))) begin
               n_fail++;
               $display("FAIL fetch_seq c%0d got v=%b pc=%h npc=%h ir=%h exp pc=%h", c, FD_VALID, FD_PC, FD_NEXTPC, FD_IR, 32'h100 + 32'(4 * (c - fv)));
            end
         end
      end
   endtask

   task automatic test_stall();
      int acc;
      int fv;
      fv = 2 - BYP;
      acc = 0;
      do_reset(1, 1'b0);
      RST = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (c > 0) @(negedge CLK);
         #1;
         if (IMEM_REQ_VALID && IMEM_REQ_READY) acc++;
         if (c >= fv) begin
            n_tests++; if (FD_VALID !== 1'b1 || FD_PC !== 32'h100) begin n_fail++; $display("FAIL stall_hold c%0d got v=%b pc=%h exp v=1 pc=00000100", c, FD_VALID, FD_PC); end
         end
      end
      n_tests++; if (acc !== 4) begin n_fail++; $display("FAIL stall_accepts got %0d exp 4", acc); end
      n_tests++; if (IMEM_REQ_VALID !== 1'b0) begin n_fail++; $display("FAIL stall_req_off got %b exp 0", IMEM_REQ_VALID); end
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         DEC_READY = 1'b1;
         #1;
         n_tests++;
         if (FD_VALID !== 1'b1 || FD_PC !== 32'h100 + 32'(4 * i) || FD_IR !== mem_word(14'h40 + 14'(i))) begin
            n_fail++;
            $display("FAIL stall_drain i%0d got v=%b pc=%h ir=%h exp pc=%h", i, FD_VALID, FD_PC, FD_IR, 32'h100 + 32'(4 * i));
         end
      end
   endtask

   task automatic test_redirect();
      int fv;
      fv = 8 - BYP;
      do_reset(3, 1'b1);
      REDIRECT = 1'b1;
      REDIRECT_PC = 32'h10;
      RST = 1'b0;
      #1;
      n_tests++; if (IMEM_REQ_VALID !== 1'b0) begin n_fail++; $display("FAIL redir_c0_req got %b exp 0", IMEM_REQ_VALID); end
      @(negedge CLK);
      REDIRECT = 1'b0;
      #1;
      n_tests++; if (IMEM_REQ_VALID !== 1'b1 || IMEM_ADDR !== 14'h4) begin n_fail++; $display("FAIL redir_req10 got v=%b a=%h exp v=1 a=0004", IMEM_REQ_VALID, IMEM_ADDR); end
      @(negedge CLK);
      #1;
      n_tests++; if (IMEM_REQ_VALID !== 1'b1 || IMEM_ADDR !== 14'h5) begin n_fail++; $display("FAIL redir_req14 got v=%b a=%h exp v=1 a=0005", IMEM_REQ_VALID, IMEM_ADDR); end
      @(negedge CLK);
      REDIRECT = 1'b1;
      REDIRECT_PC = 32'h203;
      #1;
      n_tests++; if (IMEM_REQ_VALID !== 1'b0 || FD_VALID !== 1'b0) begin n_fail++; $display("FAIL redir_cycle got req=%b fdv=%b exp 0 0", IMEM_REQ_VALID, FD_VALID); end
      @(negedge CLK);
      REDIRECT = 1'b0;
      #1;
      n_tests++; if (FD_VALID !== 1'b0 || IMEM_REQ_VALID !== 1'b1 || IMEM_ADDR !== 14'h80) begin n_fail++; $display("FAIL redir_restart got fdv=%b req=%b a=%h exp 0 1 0080", FD_VALID, IMEM_REQ_VALID, IMEM_ADDR); end
      for (int c = 5; c < fv; c++) begin
         @(negedge CLK);
         #1;
         n_tests++; if (FD_VALID !== 1'b0) begin n_fail++; $display("FAIL redir_stale c%0d got fdv=%b ir=%h exp fdv=0", c, FD_VALID, FD_IR); end
      end
      @(negedge CLK);
      #1;
      n_tests++;
      if (FD_VALID !== 1'b1 || FD_PC !== 32'h200 || FD_NEXTPC !== 32'h204 || FD_IR !== mem_word(14'h80)) begin
         n_fail++;
         $display("FAIL redir_target got v=%b pc=%h npc=%h ir=%h exp 1 00000200 00000204 %h", FD_VALID, FD_PC, FD_NEXTPC, FD_IR, mem_word(14'h80));
      end
      @(negedge CLK);
      #1;
      n_tests++; if (FD_VALID !== 1'b1 || FD_PC !== 32'h204 || FD_IR !== mem_word(14'h81)) begin n_fail++; $display("FAIL redir_next got v=%b pc=%h ir=%h exp 1 00000204", FD_VALID, FD_PC, FD_IR); end
   endtask

   task automatic test_redirect_collide();
      int fv;
      fv = 8 - BYP;
      do_reset(1, 1'b1);
      RST = 1'b0;
      repeat (5) @(negedge CLK);
      REDIRECT = 1'b1;
      REDIRECT_PC = 32'h300;
      #1;
      n_tests++; if (IMEM_REQ_VALID !== 1'b0) begin n_fail++; $display("FAIL coll_req got %b exp 0", IMEM_REQ_VALID); end
      @(negedge CLK);
      REDIRECT = 1'b0;
      #1;
      n_tests++; if (FD_VALID !== 1'b0 || IMEM_REQ_VALID !== 1'b1 || IMEM_ADDR !== 14'hC0) begin n_fail++; $display("FAIL coll_cleared got fdv=%b req=%b a=%h exp 0 1 00c0", FD_VALID, IMEM_REQ_VALID, IMEM_ADDR); end
      for (int c = 7; c <= fv + 2; c++) begin
         @(negedge CLK);
         #1;
         if (c < fv) begin
            n_tests++; if (FD_VALID !== 1'b0) begin n_fail++; $display("FAIL coll_early c%0d got %b exp 0", c, FD_VALID); end
         end else begin
            n_tests++;
            if (FD_VALID !== 1'b1 || FD_PC !== 32'h300 + 32'(4 * (c - fv)) || FD_IR !== mem_word(14'hC0 + 14'(c - fv))) begin
               n_fail++;
               $display("FAIL coll_seq c%0d got v=%b pc=%h ir=%h exp pc=%h", c, FD_VALID, FD_PC, FD_IR, 32'h300 + 32'(4 * (c - fv)));
            end
         end
      end
   endtask

   task automatic test_ready_toggle();
      logic [13:0] exp_a;
      do_reset(1, 1'b1);
      RST = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (c > 0) @(negedge CLK);
         IMEM_REQ_READY = (c % 2 == 0);
         #1;
         exp_a = 14'h40 + 14'((c + 1) / 2);
         n_tests++; if (IMEM_REQ_VALID !== 1'b1 || IMEM_ADDR !== exp_a) begin n_fail++; $display("FAIL toggle_addr c%0d got v=%b a=%h exp v=1 a=%h", c, IMEM_REQ_VALID, IMEM_ADDR, exp_a); end
      end
      @(negedge CLK);
      IMEM_REQ_READY = 1'b1;
   endtask

   task automatic test_reset_mid();
      int fv;
      fv = 2 - BYP;
      do_reset(1, 1'b0);
      RST = 1'b0;
      repeat (4) @(negedge CLK);
      #1;
      n_tests++; if (FD_VALID !== 1'b1 || FD_PC !== 32'h100) begin n_fail++; $display("FAIL midrst_pre got v=%b pc=%h exp 1 00000100", FD_VALID, FD_PC); end
      #1;
      RST = 1'b1;
      #1;
      n_tests++; if (FD_VALID !== 1'b0 || FD_IR !== 32'h13 || FD_PC !== 32'h0 || FD_NEXTPC !== 32'h4) begin n_fail++; $display("FAIL midrst_async got v=%b ir=%h pc=%h npc=%h exp 0 00000013 0 4", FD_VALID, FD_IR, FD_PC, FD_NEXTPC); end
      n_tests++; if (IMEM_REQ_VALID !== 1'b0) begin n_fail++; $display("FAIL midrst_req got %b exp 0", IMEM_REQ_VALID); end
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      DEC_READY = 1'b1;
      #1;
      n_tests++; if (IMEM_REQ_VALID !== 1'b1 || IMEM_ADDR !== 14'h40) begin n_fail++; $display("FAIL midrst_restart got v=%b a=%h exp 1 0040", IMEM_REQ_VALID, IMEM_ADDR); end
      repeat (fv) @(negedge CLK);
      #1;
      n_tests++; if (FD_VALID !== 1'b1 || FD_PC !== 32'h100 || FD_IR !== mem_word(14'h40)) begin n_fail++; $display("FAIL midrst_first got v=%b pc=%h ir=%h exp 1 00000100 %h", FD_VALID, FD_PC, FD_IR, mem_word(14'h40)); end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_stall();
      test_redirect();
      test_redirect_collide();
      test_ready_toggle();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
